// File: rtl/mc_controller_hs_if.sv
// -----------------------------------------------------------------------------
// mc_controller_hs_if
// Purpose : Bundles the opcode/memory-handshake/status signals between the
//           multicycle control FSM and the datapath/memory side.
// Signals : opcode     - current IR opcode (valid from DECODE onward)
//           mem_ready  - memory completes the outstanding request this cycle
//           stall      - freeze the controller
//           mem_req    - memory request (FETCH/MRD/MWR)
//           ctrl       - 16-bit datapath control word
//           state      - current FSM state encoding
//           trap       - controller sits in TRAP
//           trap_cause - 01 illegal opcode, 10 memory timeout, 00 none
//           retired    - retired-instruction counter
// Modports: master = controller side, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface mc_controller_hs_if #(
    parameter int OPW   = 6,
    parameter int CNT_W = 32
);
    logic [OPW-1:0]   opcode;
    logic             mem_ready;
    logic             stall;
    logic             mem_req;
    logic [15:0]      ctrl;
    logic [3:0]       state;
    logic             trap;
    logic [1:0]       trap_cause;
    logic [CNT_W-1:0] retired;

    modport master (
        input  opcode, mem_ready, stall,
        output mem_req, ctrl, state, trap, trap_cause, retired
    );

    modport slave (
        output opcode, mem_ready, stall,
        input  mem_req, ctrl, state, trap, trap_cause, retired
    );
endinterface

// File: rtl/mc_controller_hs.sv
// -----------------------------------------------------------------------------
// mc_controller_hs
// Purpose : Multicycle CPU control FSM with a memory req/ready handshake,
//           wait-state timeout, TRAP state for illegal opcodes / bus timeouts,
//           a global stall and a retired-instruction counter.
// Ports   : clk   - rising-edge clock
//           reset - synchronous, active-high
//           bus   - mc_controller_hs_if.master (opcode, mem_ready, stall in;
//                   mem_req, ctrl, state, trap, trap_cause, retired out)
// Params  : OPW (opcode width), TMO_W (wait counter width), CNT_W (retired
//           counter width), TRAP_EN (1: faults go to TRAP, 0: back to IDLE)
// -----------------------------------------------------------------------------
module mc_controller_hs #(
    parameter int OPW     = 6,
    parameter int TMO_W   = 4,
    parameter int CNT_W   = 32,
    parameter bit TRAP_EN = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    mc_controller_hs_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'h0, S_FETCH  = 4'h1, S_DECODE = 4'h2, S_ADDR   = 4'h3,
        S_MRD    = 4'h4, S_MWB    = 4'h5, S_MWR    = 4'h6, S_EXEC   = 4'h7,
        S_ALUWB  = 4'h8, S_BRANCH = 4'h9, S_JUMP   = 4'hA, S_JAL    = 4'hB,
        S_LI     = 4'hC, S_JR     = 4'hD, S_TRAP   = 4'hE
    } state_t;

    // ctrl bit positions
    localparam int CT_PC_WR    = 0;
    localparam int CT_PC_COND  = 1;
    localparam int CT_PC_JMP   = 2;
    localparam int CT_PC_REG   = 3;
    localparam int CT_IR_WR    = 4;
    localparam int CT_MEM_RD   = 5;
    localparam int CT_MEM_WR   = 6;
    localparam int CT_REG_WR   = 7;
    localparam int CT_MEM2REG  = 8;
    localparam int CT_LINK     = 9;
    localparam int CT_ALU_IMM  = 10;
    localparam int CT_ALU_ADD  = 11;
    localparam int CT_ALU_FUNC = 12;
    localparam int CT_ALU_SUB  = 13;
    localparam int CT_IMM_HI   = 14;
    localparam int CT_HALT     = 15;

    localparam state_t            FAULT_ST = TRAP_EN ? S_TRAP : S_IDLE;
    localparam logic [TMO_W-1:0]  WCNT_ONE = TMO_W'(1);
    localparam logic [CNT_W-1:0]  RET_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [TMO_W-1:0] wcnt_q, wcnt_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [1:0]       cause_q, cause_d;
    logic             retire;
    logic [1:0]       op_class;
    logic [3:0]       op_func;
    logic [15:0]      ctrl_c;

    assign op_class = bus.opcode[OPW-1:OPW-2];
    assign op_func  = bus.opcode[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            retired_q <= '0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        retire    = 1'b0;
        if (!bus.stall) begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH, S_MRD, S_MWR: begin
                    // mem_ready takes priority over the timeout on the terminal cycle
                    if (bus.mem_ready) begin
                        case (state_q)
                            S_FETCH: state_d = S_DECODE;
                            S_MRD:   state_d = S_MWB;
                            default: begin
                                state_d = S_FETCH;
                                retire  = 1'b1;
                            end
                        endcase
                    end else if (&wcnt_q) begin
                        state_d = FAULT_ST;
                        if (cause_q == 2'b00) cause_d = 2'b10;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_ONE;
                    end
                end
                S_DECODE: begin
                    case (op_class)
                        2'b11:   state_d = (op_func == 4'b1001 || op_func == 4'b1010) ? S_LI : S_ADDR;
                        2'b01:   state_d = S_EXEC;
                        2'b10:   state_d = S_BRANCH;
                        default: begin
                            case (op_func)
                                4'b0000: state_d = S_IDLE;
                                4'b0001: state_d = S_JUMP;
                                4'b0010: state_d = S_JAL;
                                4'b0011: state_d = S_JR;
                                default: begin
                                    state_d = FAULT_ST;
                                    if (cause_q == 2'b00) cause_d = 2'b01;
                                end
                            endcase
                        end
                    endcase
                end
                S_ADDR: begin
                    case (op_func)
                        4'b1011, 4'b1101: state_d = S_MRD;
                        4'b1100, 4'b1110: state_d = S_MWR;
                        default:          state_d = S_ALUWB;
                    endcase
                end
                S_EXEC, S_LI: state_d = S_ALUWB;
                S_MWB, S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
                S_TRAP:  state_d = S_TRAP;
                default: state_d = S_IDLE;
            endcase
            if (retire) retired_d = retired_q + RET_ONE;
            // Fresh timeout window on every entry into a waiting state
            if ((state_d != state_q) && (state_d inside {S_FETCH, S_MRD, S_MWR}))
                wcnt_d = '0;
        end
    end

    always_comb begin : ctrl_decode
        ctrl_c = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_c[CT_IR_WR]   = 1'b1;
                ctrl_c[CT_MEM_RD]  = 1'b1;
                ctrl_c[CT_PC_WR]   = 1'b1;
                ctrl_c[CT_ALU_ADD] = 1'b1;
            end
            S_ADDR: begin
                ctrl_c[CT_ALU_IMM] = 1'b1;
                ctrl_c[CT_ALU_ADD] = 1'b1;
            end
            S_MRD:   ctrl_c[CT_MEM_RD] = 1'b1;
            S_MWB: begin
                ctrl_c[CT_REG_WR]  = 1'b1;
                ctrl_c[CT_MEM2REG] = 1'b1;
            end
            S_MWR:   ctrl_c[CT_MEM_WR] = 1'b1;
            S_EXEC:  ctrl_c[CT_ALU_FUNC] = 1'b1;
            S_ALUWB: ctrl_c[CT_REG_WR] = 1'b1;
            S_BRANCH: begin
                ctrl_c[CT_PC_COND] = 1'b1;
                ctrl_c[CT_ALU_SUB] = 1'b1;
            end
            S_JUMP: begin
                ctrl_c[CT_PC_WR]  = 1'b1;
                ctrl_c[CT_PC_JMP] = 1'b1;
            end
            S_JAL: begin
                ctrl_c[CT_PC_WR]  = 1'b1;
                ctrl_c[CT_PC_JMP] = 1'b1;
                ctrl_c[CT_LINK]   = 1'b1;
                ctrl_c[CT_REG_WR] = 1'b1;
            end
            S_LI: begin
                ctrl_c[CT_ALU_IMM] = 1'b1;
                ctrl_c[CT_IMM_HI]  = (op_func == 4'b1010);
            end
            S_JR: begin
                ctrl_c[CT_PC_WR]  = 1'b1;
                ctrl_c[CT_PC_REG] = 1'b1;
            end
            S_TRAP:  ctrl_c[CT_HALT] = 1'b1;
            default: ctrl_c = '0;
        endcase
    end

    assign bus.ctrl       = ctrl_c;
    assign bus.state      = state_q;
    assign bus.mem_req    = (state_q inside {S_FETCH, S_MRD, S_MWR});
    assign bus.trap       = (state_q == S_TRAP);
    assign bus.trap_cause = cause_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_controller_hs.sv
// -----------------------------------------------------------------------------
// tb_mc_controller_hs
// Drives the controller one instruction at a time with a reactive memory
// responder and compares the observed state trace against an instruction-level
// reference model that lists the states each opcode should visit.
// A second instance built with TRAP_EN=0 shares the inputs.
// -----------------------------------------------------------------------------
module tb_mc_controller_hs;
    localparam int OPW   = 6;
    localparam int TMO_W = 4;
    localparam int CNT_W = 32;
    localparam int LIM   = 1 << TMO_W;

    localparam logic [3:0] S_IDLE = 4'h0, S_FETCH = 4'h1, S_DECODE = 4'h2, S_ADDR = 4'h3,
        S_MRD = 4'h4, S_MWB = 4'h5, S_MWR = 4'h6, S_EXEC = 4'h7, S_ALUWB = 4'h8,
        S_BRANCH = 4'h9, S_JUMP = 4'hA, S_JAL = 4'hB, S_LI = 4'hC, S_JR = 4'hD,
        S_TRAP = 4'hE, S_NONE = 4'hF;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       stall;

    int total = 0;
    int bad   = 0;

    logic [3:0]  obs_st[$];
    logic [15:0] obs_ctrl[$];
    logic        obs_req[$];
    logic [31:0] obs_ret[$];
    logic [3:0]  exp_st[$];
    logic [3:0]  end_st, exp_end;
    logic [1:0]  exp_cause;
    logic [3:0]  m_stall_st;
    int          m_left;

    mc_controller_hs_if #(.OPW(OPW), .CNT_W(CNT_W)) bus ();
    mc_controller_hs_if #(.OPW(OPW), .CNT_W(CNT_W)) bus_nt ();

    assign bus.opcode       = opcode;
    assign bus.mem_ready    = mem_ready;
    assign bus.stall        = stall;
    assign bus_nt.opcode    = opcode;
    assign bus_nt.mem_ready = mem_ready;
    assign bus_nt.stall     = stall;

    mc_controller_hs #(.OPW(OPW), .TMO_W(TMO_W), .CNT_W(CNT_W), .TRAP_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    mc_controller_hs #(.OPW(OPW), .TMO_W(TMO_W), .CNT_W(CNT_W), .TRAP_EN(1'b0)) dut_nt (
        .clk(clk), .reset(reset), .bus(bus_nt));

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    task automatic push_exp(input logic [3:0] s);
        exp_st.push_back(s);
        if (s == m_stall_st && m_left > 0) begin
            repeat (m_left) exp_st.push_back(s);
            m_left = 0;
        end
    endtask

    // Lists the states one instruction visits starting in FETCH, plus where it ends.
    task automatic model_instr(input logic [5:0] op, input int fd, input int md,
                               input logic [3:0] stall_st, input int stall_len);
        logic [1:0] cls;
        logic [3:0] fn;
        logic [3:0] mst;
        cls = op[5:4];
        fn  = op[3:0];
        m_stall_st = stall_st;
        m_left     = stall_len;
        exp_st.delete();
        exp_end   = S_FETCH;
        exp_cause = 2'b00;
        if (fd >= LIM) begin
            repeat (LIM) push_exp(S_FETCH);
            exp_end = S_TRAP; exp_cause = 2'b10;
            return;
        end
        repeat (fd + 1) push_exp(S_FETCH);
        push_exp(S_DECODE);
        mst = S_NONE;
        if (cls == 2'b11) begin
            if (fn == 4'd9 || fn == 4'd10) begin
                push_exp(S_LI); push_exp(S_ALUWB);
            end else begin
                push_exp(S_ADDR);
                if (fn == 4'd11 || fn == 4'd13) mst = S_MRD;
                else if (fn == 4'd12 || fn == 4'd14) mst = S_MWR;
                else push_exp(S_ALUWB);
            end
        end else if (cls == 2'b01) begin
            push_exp(S_EXEC); push_exp(S_ALUWB);
        end else if (cls == 2'b10) begin
            push_exp(S_BRANCH);
        end else begin
            if (fn == 4'd0) exp_end = S_IDLE;
            else if (fn == 4'd1) push_exp(S_JUMP);
            else if (fn == 4'd2) push_exp(S_JAL);
            else if (fn == 4'd3) push_exp(S_JR);
            else begin exp_end = S_TRAP; exp_cause = 2'b01; end
        end
        if (mst != S_NONE) begin
            if (md >= LIM) begin
                repeat (LIM) push_exp(mst);
                exp_end = S_TRAP; exp_cause = 2'b10;
                return;
            end
            repeat (md + 1) push_exp(mst);
            if (mst == S_MRD) push_exp(S_MWB);
        end
    endtask

    // ---------------- stimulus drivers ----------------
    task automatic do_reset();
        reset = 1'b1; stall = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic go_fetch();
        stall = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    // Runs from FETCH until the next FETCH/IDLE/TRAP entry; memory answers after
    // fd (fetch) or md (data) waiting cycles; stall_len stall cycles at stall_st.
    task automatic run_instr(input logic [5:0] op, input int fd, input int md,
                             input logic [3:0] stall_st, input int stall_len);
        int cnt;
        int left;
        logic [3:0] prev;
        logic [3:0] cur;
        cnt = 0; left = stall_len;
        obs_st.delete(); obs_ctrl.delete(); obs_req.delete(); obs_ret.delete();
        opcode = op;
        cur    = bus.state;
        end_st = S_NONE;
        for (int cyc = 0; cyc < 200; cyc++) begin
            obs_st.push_back(cur);
            obs_ctrl.push_back(bus.ctrl);
            obs_req.push_back(bus.mem_req);
            obs_ret.push_back(bus.retired);
            stall = (cur == stall_st) && (left > 0);
            if (stall) left--;
            if (stall) mem_ready = 1'($urandom_range(0, 1));
            else if (cur == S_FETCH) mem_ready = (cnt == fd);
            else if (cur == S_MRD || cur == S_MWR) mem_ready = (cnt == md);
            else mem_ready = 1'($urandom_range(0, 1));
            prev = cur;
            @(posedge clk);
            #1;
            cur = bus.state;
            if (cur != prev) cnt = 0;
            else if (!stall) cnt++;
            if (cur != prev && (cur == S_FETCH || cur == S_IDLE || cur == S_TRAP)) begin
                end_st = cur;
                break;
            end
        end
        stall = 1'b0;
        mem_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; mem_ready = 1'b1; opcode = 6'($urandom);
        @(posedge clk);
        #1;
        total++; if (bus.state !== S_IDLE) begin bad++; $display("FAIL reset_state: got %0h want %0h", bus.state, S_IDLE); end
        total++; if (bus.ctrl !== 16'h0000) begin bad++; $display("FAIL reset_ctrl: got %h want 0000", bus.ctrl); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); end
        total++; if (bus.trap !== 1'b0) begin bad++; $display("FAIL reset_trap: got %b want 0", bus.trap); end
        total++; if (bus.trap_cause !== 2'b00) begin bad++; $display("FAIL reset_cause: got %b want 00", bus.trap_cause); end
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL reset_retired: got %0d want 0", bus.retired); end
        reset = 1'b0;
    endtask

    task automatic test_rtype();
        logic [5:0] op;
        do_reset();
        go_fetch();
        op = {2'b01, 4'($urandom_range(0, 15))};
        run_instr(op, 0, 0, S_NONE, 0);
        model_instr(op, 0, 0, S_NONE, 0);
        total++; if (obs_st.size() != exp_st.size()) begin bad++; $display("FAIL rtype_len: got %0d want %0d", obs_st.size(), exp_st.size()); end
        for (int i = 0; i < obs_st.size() && i < exp_st.size(); i++) begin
            total++; if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL rtype_state[%0d]: got %0h want %0h", i, obs_st[i], exp_st[i]); end
        end
        total++; if (obs_ctrl[0] !== 16'h0831) begin bad++; $display("FAIL rtype_fetch_ctrl: got %h want 0831", obs_ctrl[0]); end
        total++; if (end_st !== S_FETCH) begin bad++; $display("FAIL rtype_end: got %0h want %0h", end_st, S_FETCH); end
        total++; if (bus.retired !== 32'd1) begin bad++; $display("FAIL rtype_retired: got %0d want 1", bus.retired); end
        $display("rtype op=%b states=%0d retired=%0d", op, obs_st.size(), bus.retired);
    endtask

    task automatic test_load();
        int n;
        do_reset();
        go_fetch();
        run_instr(6'b111011, 0, 3, S_NONE, 0);
        model_instr(6'b111011, 0, 3, S_NONE, 0);
        total++; if (obs_st.size() != exp_st.size()) begin bad++; $display("FAIL load_len: got %0d want %0d", obs_st.size(), exp_st.size()); end
        for (int i = 0; i < obs_st.size() && i < exp_st.size(); i++) begin
            total++; if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL load_state[%0d]: got %0h want %0h", i, obs_st[i], exp_st[i]); end
        end
        n = 0;
        for (int i = 0; i < obs_st.size(); i++) if (obs_st[i] == S_MRD && obs_req[i] && obs_ctrl[i][5]) n++;
        total++; if (n != 4) begin bad++; $display("FAIL load_req_cycles: got %0d want 4", n); end
        total++; if (obs_st[obs_st.size()-1] !== S_MWB) begin bad++; $display("FAIL load_mwb: got %0h want %0h", obs_st[obs_st.size()-1], S_MWB); end
        total++; if (bus.retired !== 32'd1) begin bad++; $display("FAIL load_retired: got %0d want 1", bus.retired); end
        $display("load op=111011 mrd_req_cycles=%0d retired=%0d", n, bus.retired);
    endtask

    task automatic test_store_timeout();
        int n;
        do_reset();
        go_fetch();
        run_instr(6'b111100, 1, 99, S_NONE, 0);
        model_instr(6'b111100, 1, 99, S_NONE, 0);
        n = 0;
        for (int i = 0; i < obs_st.size(); i++) if (obs_st[i] == S_MWR && obs_ctrl[i][6]) n++;
        total++; if (n != LIM) begin bad++; $display("FAIL store_mwr_cycles: got %0d want %0d", n, LIM); end
        total++; if (end_st !== exp_end) begin bad++; $display("FAIL store_end: got %0h want %0h", end_st, exp_end); end
        total++; if (bus.trap !== 1'b1) begin bad++; $display("FAIL store_trap: got %b want 1", bus.trap); end
        total++; if (bus.trap_cause !== exp_cause) begin bad++; $display("FAIL store_cause: got %b want %b", bus.trap_cause, exp_cause); end
        total++; if (bus.ctrl !== 16'h8000) begin bad++; $display("FAIL store_ctrl: got %h want 8000", bus.ctrl); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL store_mem_req: got %b want 0", bus.mem_req); end
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL store_retired: got %0d want 0", bus.retired); end
        total++; if (bus_nt.state !== S_IDLE) begin bad++; $display("FAIL store_notrap_state: got %0h want %0h", bus_nt.state, S_IDLE); end
        for (int k = 0; k < 4; k++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode = 6'($urandom);
            @(posedge clk);
            #1;
            total++; if (bus.state !== S_TRAP) begin bad++; $display("FAIL trap_absorb[%0d]: got %0h want %0h", k, bus.state, S_TRAP); end
        end
        $display("store op=111100 mwr_cycles=%0d cause=%b", n, bus.trap_cause);
    endtask

    task automatic test_terminal();
        do_reset();
        go_fetch();
        run_instr(6'b111101, LIM - 1, LIM - 1, S_NONE, 0);
        model_instr(6'b111101, LIM - 1, LIM - 1, S_NONE, 0);
        total++; if (obs_st.size() != exp_st.size()) begin bad++; $display("FAIL terminal_len: got %0d want %0d", obs_st.size(), exp_st.size()); end
        total++; if (end_st !== S_FETCH) begin bad++; $display("FAIL terminal_end: got %0h want %0h", end_st, S_FETCH); end
        total++; if (bus.trap_cause !== 2'b00) begin bad++; $display("FAIL terminal_cause: got %b want 00", bus.trap_cause); end
        total++; if (bus.retired !== 32'd1) begin bad++; $display("FAIL terminal_retired: got %0d want 1", bus.retired); end
        $display("terminal ready on last wait cycle end=%0h retired=%0d", end_st, bus.retired);
    endtask

    task automatic test_illegal();
        do_reset();
        go_fetch();
        run_instr(6'b000111, 0, 0, S_NONE, 0);
        model_instr(6'b000111, 0, 0, S_NONE, 0);
        total++; if (end_st !== exp_end) begin bad++; $display("FAIL illegal_end: got %0h want %0h", end_st, exp_end); end
        total++; if (bus.trap_cause !== 2'b01) begin bad++; $display("FAIL illegal_cause: got %b want 01", bus.trap_cause); end
        total++; if (bus.ctrl !== 16'h8000) begin bad++; $display("FAIL illegal_ctrl: got %h want 8000", bus.ctrl); end
        total++; if (bus_nt.state !== S_IDLE) begin bad++; $display("FAIL illegal_notrap_state: got %0h want %0h", bus_nt.state, S_IDLE); end
        total++; if (bus_nt.trap !== 1'b0) begin bad++; $display("FAIL illegal_notrap_trap: got %b want 0", bus_nt.trap); end
        $display("illegal op=000111 end=%0h cause=%b", end_st, bus.trap_cause);
    endtask

    task automatic test_stall();
        logic [5:0] op;
        int n;
        do_reset();
        go_fetch();
        op = {2'b01, 4'($urandom_range(0, 15))};
        run_instr(op, 0, 0, S_NONE, 0);
        run_instr(op, 0, 0, S_EXEC, 5);
        model_instr(op, 0, 0, S_EXEC, 5);
        total++; if (obs_st.size() != exp_st.size()) begin bad++; $display("FAIL stall_len: got %0d want %0d", obs_st.size(), exp_st.size()); end
        for (int i = 0; i < obs_st.size() && i < exp_st.size(); i++) begin
            total++; if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL stall_state[%0d]: got %0h want %0h", i, obs_st[i], exp_st[i]); end
        end
        n = 0;
        for (int i = 0; i < obs_st.size(); i++) begin
            if (obs_st[i] == S_EXEC) begin
                n++;
                total++; if (obs_ret[i] !== 32'd1) begin bad++; $display("FAIL stall_retired[%0d]: got %0d want 1", i, obs_ret[i]); end
                total++; if (obs_ctrl[i] !== 16'h1000) begin bad++; $display("FAIL stall_ctrl[%0d]: got %h want 1000", i, obs_ctrl[i]); end
            end
        end
        total++; if (n != 6) begin bad++; $display("FAIL stall_exec_cycles: got %0d want 6", n); end
        total++; if (bus.retired !== 32'd2) begin bad++; $display("FAIL stall_retired_end: got %0d want 2", bus.retired); end
        $display("stall op=%b exec_cycles=%0d retired=%0d", op, n, bus.retired);
    endtask

    task automatic test_reset_mid();
        do_reset();
        go_fetch();
        run_instr(6'b010000, 0, 0, S_NONE, 0);
        opcode = 6'b111011;
        for (int k = 0; k < 20 && bus.state != S_MRD; k++) begin
            mem_ready = (bus.state == S_FETCH);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.state !== S_MRD || bus.mem_req !== 1'b1) begin bad++; $display("FAIL midreset_pre: state %0h req %b want %0h 1", bus.state, bus.mem_req, S_MRD); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.state !== S_IDLE) begin bad++; $display("FAIL midreset_state: got %0h want %0h", bus.state, S_IDLE); end
        total++; if (bus.mem_req !== 1'b0) begin bad++; $display("FAIL midreset_mem_req: got %b want 0", bus.mem_req); end
        total++; if (bus.retired !== 32'd0) begin bad++; $display("FAIL midreset_retired: got %0d want 0", bus.retired); end
        total++; if (bus.trap_cause !== 2'b00) begin bad++; $display("FAIL midreset_cause: got %b want 00", bus.trap_cause); end
        reset = 1'b0;
        $display("midreset state=%0h mem_req=%b", bus.state, bus.mem_req);
    endtask

    task automatic test_random();
        logic [3:0] stall_pool [6];
        logic [1:0] cls;
        logic [3:0] fn;
        logic [5:0] op;
        logic [3:0] sst;
        int fd, md, slen;
        int model_ret;
        stall_pool = '{S_NONE, S_DECODE, S_EXEC, S_ALUWB, S_ADDR, S_LI};
        do_reset();
        go_fetch();
        model_ret = 0;
        for (int n = 0; n < 40; n++) begin
            cls  = 2'($urandom_range(0, 3));
            fn   = (cls == 2'b00) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            op   = {cls, fn};
            fd   = $urandom_range(0, 3);
            md   = ($urandom_range(0, 7) == 0) ? LIM - 1 : $urandom_range(0, 4);
            sst  = stall_pool[$urandom_range(0, 5)];
            slen = $urandom_range(1, 4);
            run_instr(op, fd, md, sst, slen);
            model_instr(op, fd, md, sst, slen);
            if (exp_end == S_FETCH) model_ret++;
            total++; if (obs_st.size() != exp_st.size()) begin bad++; $display("FAIL rand%0d_len: got %0d want %0d", n, obs_st.size(), exp_st.size()); end
            for (int i = 0; i < obs_st.size() && i < exp_st.size(); i++) begin
                total++; if (obs_st[i] !== exp_st[i]) begin bad++; $display("FAIL rand%0d_state[%0d]: got %0h want %0h", n, i, obs_st[i], exp_st[i]); end
            end
            for (int i = 0; i < obs_st.size(); i++) begin
                total++;
                if (obs_req[i] !== (obs_st[i] == S_FETCH || obs_st[i] == S_MRD || obs_st[i] == S_MWR)) begin
                    bad++; $display("FAIL rand%0d_mem_req[%0d]: got %b in state %0h", n, i, obs_req[i], obs_st[i]);
                end
                if (obs_st[i] == S_FETCH) begin
                    total++; if (obs_ctrl[i] !== 16'h0831) begin bad++; $display("FAIL rand%0d_fetch_ctrl[%0d]: got %h want 0831", n, i, obs_ctrl[i]); end
                end
                if (obs_st[i] == S_LI) begin
                    total++; if (obs_ctrl[i][14] !== (fn == 4'b1010)) begin bad++; $display("FAIL rand%0d_imm_hi: got %b want %b", n, obs_ctrl[i][14], fn == 4'b1010); end
                end
            end
            total++; if (end_st !== exp_end) begin bad++; $display("FAIL rand%0d_end: got %0h want %0h", n, end_st, exp_end); end
            total++; if (bus.retired !== 32'(model_ret)) begin bad++; $display("FAIL rand%0d_retired: got %0d want %0d", n, bus.retired, model_ret); end
            $display("instr %0d op=%b fd=%0d md=%0d stall=%0h/%0d cycles=%0d end=%0h retired=%0d",
                     n, op, fd, md, sst, slen, obs_st.size(), end_st, bus.retired);
            if (end_st == S_IDLE) begin
                go_fetch();
                total++; if (bus.state !== S_FETCH) begin bad++; $display("FAIL rand%0d_restart: got %0h want %0h", n, bus.state, S_FETCH); end
            end else if (end_st != S_FETCH) begin
                do_reset();
                go_fetch();
                model_ret = 0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
        test_reset();
        test_rtype();
        test_load();
        test_store_timeout();
        test_terminal();
        test_illegal();
        test_stall();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
